// File: rtl/wac_adc_pkg.sv
// Shared constants and state encoding for the WAC serial ADC acquisition front end.
package wac_adc_pkg;

   localparam int ADC_BITS   = 12;
   localparam int LEAD_ZEROS = 4;
   localparam int FRAME_BITS = LEAD_ZEROS + ADC_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      QUIET = 2'd2
   } adcState_t;

endpackage

// File: rtl/wac_adc_acq_if.sv
// ADC serial pins plus the sample/strobe pair handed to WacComCtrl.
// readyAdc is a one-cycle strobe; datoAdc is valid in that cycle and holds until the next strobe (no back-pressure).
interface wac_adc_acq_if;
   import wac_adc_pkg::*;

   logic                adcCs;
   logic                adcSclk;
   logic                adcSdata;
   logic [ADC_BITS-1:0] datoAdc;
   logic                readyAdc;

   modport master (
      output adcCs, adcSclk, datoAdc, readyAdc,
      input  adcSdata
   );

   modport slave (
      input  adcCs, adcSclk, datoAdc, readyAdc,
      output adcSdata
   );

endinterface

// File: rtl/wac_sclk_gen.sv
// SCLK divider: toggles adcSclk every CLK_DIV enabled cycles and flags each edge for one cycle.
module wac_sclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic adcSclk,
   output logic sclkRise,
   output logic sclkFall
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0] divCnt;
   logic       halfDone;

   assign halfDone = (divCnt == DIV_LAST);

   // Strobes are registered with the edge, so they are high in the first cycle of the new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divCnt   <= 8'd0;
         adcSclk  <= 1'b1;
         sclkRise <= 1'b0;
         sclkFall <= 1'b0;
      end else if (clr) begin
         divCnt   <= 8'd0;
         adcSclk  <= 1'b1;
         sclkRise <= 1'b0;
         sclkFall <= 1'b0;
      end else if (en) begin
         if (halfDone) begin
            divCnt   <= 8'd0;
            adcSclk  <= ~adcSclk;
            sclkRise <= ~adcSclk;
            sclkFall <= adcSclk;
         end else begin
            divCnt   <= divCnt + 8'd1;
            sclkRise <= 1'b0;
            sclkFall <= 1'b0;
         end
      end else begin
         sclkRise <= 1'b0;
         sclkFall <= 1'b0;
      end
   end

endmodule

// File: rtl/wac_adc_acq.sv
// AD7476-style acquisition FSM: frames a 16-clock SPI read per conversion, single or burst,
// and hands each 12-bit result to WacComCtrl with a readyAdc strobe.
module wac_adc_acq
   import wac_adc_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int QUIET_CYC = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ADC_En,
   input  logic          modeAdc,
   input  logic [11:0]   nSamples,
   input  logic          flag_adc_seq,
   wac_adc_acq_if.master adcBus,
   output logic          busyAdc,
   output logic          doneAdc,
   output logic          ovrAdc,
   output logic [11:0]   sampleCnt,
   output adcState_t     stateDbg
);

   adcState_t           state, stateNxt;
   logic                flagQ, trigEdge;
   logic                csQ, csNxt;
   logic [ADC_BITS-1:0] shiftQ, shiftNxt, datoQ, datoNxt;
   logic [4:0]          bitCnt, bitCntNxt;
   logic [7:0]          quietCnt, quietCntNxt;
   logic [11:0]         target, targetNxt, cntNxt;
   logic                readyQ, readyNxt, doneNxt, busyNxt, ovrNxt;
   logic                sclk, sclkRise, sclkFall, sclkClr, sclkEn;

   assign trigEdge = flag_adc_seq & ~flagQ;
   assign sclkEn   = (state == CONV);
   assign sclkClr  = (stateNxt != CONV);

   wac_sclk_gen #(.CLK_DIV(CLK_DIV)) sclkGen (
      .clk      (clk),
      .rst      (rst),
      .en       (sclkEn),
      .clr      (sclkClr),
      .adcSclk  (sclk),
      .sclkRise (sclkRise),
      .sclkFall (sclkFall)
   );

   always_comb begin
      stateNxt    = state;
      csNxt       = csQ;
      shiftNxt    = shiftQ;
      datoNxt     = datoQ;
      bitCntNxt   = bitCnt;
      quietCntNxt = quietCnt;
      targetNxt   = target;
      cntNxt      = sampleCnt;
      busyNxt     = busyAdc;
      ovrNxt      = ovrAdc;
      readyNxt    = 1'b0;
      doneNxt     = 1'b0;
      if (!ADC_En) begin
         // Abort outranks any trigger or frame completion in the same cycle.
         stateNxt    = IDLE;
         csNxt       = 1'b1;
         busyNxt     = 1'b0;
         ovrNxt      = 1'b0;
         bitCntNxt   = 5'd0;
         quietCntNxt = 8'd0;
      end else begin
         if (trigEdge && state != IDLE) ovrNxt = 1'b1;
         case (state)
            IDLE: begin
               if (trigEdge) begin
                  cntNxt    = 12'd0;
                  bitCntNxt = 5'd0;
                  if (modeAdc && nSamples == 12'd0) begin
                     doneNxt = 1'b1;
                  end else begin
                     targetNxt = modeAdc ? nSamples : 12'd1;
                     busyNxt   = 1'b1;
                     csNxt     = 1'b0;
                     stateNxt  = CONV;
                  end
               end
            end
            CONV: begin
               // bitCnt counts falling edges; the 16th rise always follows the 16th fall.
               if (sclkFall) bitCntNxt = bitCnt + 5'd1;
               if (sclkRise) begin
                  shiftNxt = {shiftQ[ADC_BITS-2:0], adcBus.adcSdata};
                  if (bitCnt == 5'(FRAME_BITS)) begin
                     bitCntNxt   = 5'd0;
                     csNxt       = 1'b1;
                     datoNxt     = shiftNxt;
                     readyNxt    = 1'b1;
                     cntNxt      = sampleCnt + 12'd1;
                     quietCntNxt = 8'd0;
                     stateNxt    = QUIET;
                  end
               end
            end
            QUIET: begin
               if (quietCnt == 8'(QUIET_CYC - 1)) begin
                  quietCntNxt = 8'd0;
                  if (sampleCnt == target) begin
                     doneNxt  = 1'b1;
                     busyNxt  = 1'b0;
                     stateNxt = IDLE;
                  end else begin
                     csNxt    = 1'b0;
                     stateNxt = CONV;
                  end
               end else begin
                  quietCntNxt = quietCnt + 8'd1;
               end
            end
            default: stateNxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         flagQ     <= 1'b0;
         csQ       <= 1'b1;
         shiftQ    <= '0;
         datoQ     <= '0;
         bitCnt    <= 5'd0;
         quietCnt  <= 8'd0;
         target    <= 12'd0;
         sampleCnt <= 12'd0;
         readyQ    <= 1'b0;
         doneAdc   <= 1'b0;
         busyAdc   <= 1'b0;
         ovrAdc    <= 1'b0;
      end else begin
         state     <= stateNxt;
         flagQ     <= flag_adc_seq;
         csQ       <= csNxt;
         shiftQ    <= shiftNxt;
         datoQ     <= datoNxt;
         bitCnt    <= bitCntNxt;
         quietCnt  <= quietCntNxt;
         target    <= targetNxt;
         sampleCnt <= cntNxt;
         readyQ    <= readyNxt;
         doneAdc   <= doneNxt;
         busyAdc   <= busyNxt;
         ovrAdc    <= ovrNxt;
      end
   end

   assign adcBus.adcCs    = csQ;
   assign adcBus.adcSclk  = sclk;
   assign adcBus.datoAdc  = datoQ;
   assign adcBus.readyAdc = readyQ;
   assign stateDbg        = state;

endmodule

// File: tb/tb_wac_adc_acq.sv
// Bench for wac_adc_acq: cycle-indexed timeline model of expected pin activity plus an ADC serial model.
module tb_wac_adc_acq;
   import wac_adc_pkg::*;

   localparam int D    = 2;
   localparam int Q    = 4;
   localparam int PER  = 32*D + 1 + Q;
   localparam int MAXC = 2048;
   localparam int S_CS = 0, S_SCLK = 1, S_DATO = 2, S_READY = 3, S_BUSY = 4;
   localparam int S_DONE = 5, S_OVR = 6, S_CNT = 7, S_STATE = 8;

   logic        clk = 1'b0, rst = 1'b1, adcEn = 1'b0, modeAdc = 1'b0, flag = 1'b0;
   logic [11:0] nSamples = 12'd0;
   logic        busyAdc, doneAdc, ovrAdc;
   logic [11:0] sampleCnt;
   adcState_t   stateDbg;
   int          cyc = 0;
   int          total = 0, bad = 0;

   wac_adc_acq_if bus();

   wac_adc_acq #(.CLK_DIV(D), .QUIET_CYC(Q)) dut (
      .clk          (clk),
      .rst          (rst),
      .ADC_En       (adcEn),
      .modeAdc      (modeAdc),
      .nSamples     (nSamples),
      .flag_adc_seq (flag),
      .adcBus       (bus.master),
      .busyAdc      (busyAdc),
      .doneAdc      (doneAdc),
      .ovrAdc       (ovrAdc),
      .sampleCnt    (sampleCnt),
      .stateDbg     (stateDbg)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // expected timeline, one entry per clock cycle
   bit          expCs[MAXC], expSclk[MAXC], expReady[MAXC], expDone[MAXC], expBusy[MAXC];
   logic [11:0] expDato[MAXC], expCnt[MAXC];
   typedef struct {int c; int sel; logic [11:0] v;} pin_t;
   pin_t        pinQ[$];
   logic [11:0] adcBase = 12'd0;

   task automatic setCnt(int c, logic [11:0] v);
      for (int k = c; k < MAXC; k++) expCnt[k] = v;
   endtask

   // Accepted trigger detected in cycle t, n conversions.
   task automatic schedConv(int t, int n, logic [11:0] base);
      int fs, r, dn;
      setCnt(t + 1, 12'd0);
      if (n == 0) begin
         expDone[t + 1] = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         fs = t + 1 + i*PER;
         for (int c = fs; c <= fs + 32*D; c++) expCs[c] = 1'b0;
         for (int j = 0; j < 16; j++)
            for (int c = fs + (2*j+1)*D; c < fs + (2*j+2)*D; c++) expSclk[c] = 1'b0;
         r = fs + 32*D + 1;
         expReady[r] = 1'b1;
         expDato[r]  = base + 12'(i);
         setCnt(r, 12'(i + 1));
      end
      dn = t + n*PER + 1;
      expDone[dn] = 1'b1;
      for (int c = t + 1; c < dn; c++) expBusy[c] = 1'b1;
   endtask

   // Everything from cycle a on returns to idle; sampleCnt keeps its value.
   task automatic cutAt(int a);
      logic [11:0] hold;
      hold = expCnt[a - 1];
      for (int k = a; k < MAXC; k++) begin
         expCs[k] = 1'b1; expSclk[k] = 1'b1; expReady[k] = 1'b0;
         expDone[k] = 1'b0; expBusy[k] = 1'b0; expCnt[k] = hold;
      end
   endtask

   task automatic pin(int c, int sel, logic [11:0] v);
      pin_t p;
      p.c = c; p.sel = sel; p.v = v;
      pinQ.push_back(p);
   endtask

   // driver tasks
   task automatic driveAt(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic trigger(logic mode, logic [11:0] n, logic [11:0] base, bit accept, output int t);
      modeAdc  = mode;
      nSamples = n;
      flag     = 1'b1;
      t        = cyc;
      if (accept) begin
         adcBase = base;
         schedConv(t, mode ? int'(n) : 1, base);
      end
      @(posedge clk);
      #1;
      flag = 1'b0;
   endtask

   // ADC model: next bit out on each SCLK fall, word = adcBase + frame index within the run
   logic [15:0] curWord = 16'd0;
   logic [11:0] frameNo = 12'd0;
   int          fallCnt = 0;
   logic        prevCs = 1'b1, prevSclk = 1'b1;
   always @(posedge clk) begin
      #2;
      if (bus.adcCs) begin
         fallCnt      = 0;
         bus.adcSdata = 1'b0;
      end else begin
         if (prevCs) begin
            curWord = {4'b0101, adcBase + frameNo};
            frameNo = frameNo + 12'd1;
         end
         if (prevSclk && !bus.adcSclk && fallCnt < 16) begin
            bus.adcSdata = curWord[15 - fallCnt];
            fallCnt++;
         end
      end
      if (!busyAdc) frameNo = 12'd0;
      prevCs   = bus.adcCs;
      prevSclk = bus.adcSclk;
   end

   // scoreboard
   function automatic logic [11:0] sigOf(int sel);
      case (sel)
         S_CS:    return 12'(bus.adcCs);
         S_SCLK:  return 12'(bus.adcSclk);
         S_DATO:  return bus.datoAdc;
         S_READY: return 12'(bus.readyAdc);
         S_BUSY:  return 12'(busyAdc);
         S_DONE:  return 12'(doneAdc);
         S_OVR:   return 12'(ovrAdc);
         S_CNT:   return sampleCnt;
         default: return 12'(stateDbg);
      endcase
   endfunction

   function automatic string selName(int sel);
      case (sel)
         S_CS:    return "adcCs";
         S_SCLK:  return "adcSclk";
         S_DATO:  return "datoAdc";
         S_READY: return "readyAdc";
         S_BUSY:  return "busyAdc";
         S_DONE:  return "doneAdc";
         S_OVR:   return "ovrAdc";
         S_CNT:   return "sampleCnt";
         default: return "state";
      endcase
   endfunction

   task automatic chk(string name, logic [11:0] act, logic [11:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         chk("adcCs", 12'(bus.adcCs), 12'(expCs[cyc]));
         chk("adcSclk", 12'(bus.adcSclk), 12'(expSclk[cyc]));
         chk("readyAdc", 12'(bus.readyAdc), 12'(expReady[cyc]));
         chk("doneAdc", 12'(doneAdc), 12'(expDone[cyc]));
         chk("busyAdc", 12'(busyAdc), 12'(expBusy[cyc]));
         chk("sampleCnt", sampleCnt, expCnt[cyc]);
         if (expReady[cyc]) chk("datoAdc", bus.datoAdc, expDato[cyc]);
      end
      foreach (pinQ[i])
         if (pinQ[i].c == cyc) chk(selName(pinQ[i].sel), sigOf(pinQ[i].sel), pinQ[i].v);
   end

   // directed sequence with hand-computed pins
   initial begin
      int t, t2, a;
      for (int c = 0; c < MAXC; c++) begin
         expCs[c] = 1'b1; expSclk[c] = 1'b1; expReady[c] = 1'b0; expDone[c] = 1'b0;
         expBusy[c] = 1'b0; expDato[c] = 12'd0; expCnt[c] = 12'd0;
      end
      pin(1, S_CS, 12'd1);   pin(1, S_SCLK, 12'd1);  pin(1, S_DATO, 12'd0);
      pin(1, S_READY, 12'd0); pin(1, S_BUSY, 12'd0); pin(1, S_DONE, 12'd0);
      pin(1, S_OVR, 12'd0);  pin(1, S_CNT, 12'd0);   pin(1, S_STATE, 12'(IDLE));
      driveAt(3);
      rst   = 1'b0;
      adcEn = 1'b1;

      // single conversion
      driveAt(6);
      trigger(1'b0, 12'd0, 12'hABC, 1'b1, t);
      pin(t + 1, S_CS, 12'd0);
      pin(t + 66, S_READY, 12'd1); pin(t + 66, S_DATO, 12'hABC);
      pin(t + 70, S_DONE, 12'd1);  pin(t + 70, S_CNT, 12'd1);

      // burst of five, ramp data
      driveAt(t + 75);
      trigger(1'b1, 12'd5, 12'h100, 1'b1, t);
      pin(t + 135, S_READY, 12'd1); pin(t + 135, S_DATO, 12'h101);
      pin(t + 347, S_CNT, 12'd5);   pin(t + 347, S_DATO, 12'h104);
      pin(t + 347, S_BUSY, 12'd0);

      // overrun: second edge mid-frame is ignored but flagged
      driveAt(t + 350);
      trigger(1'b0, 12'd0, 12'h3C5, 1'b1, t);
      driveAt(t + 30);
      trigger(1'b0, 12'd0, 12'h000, 1'b0, t2);
      pin(t + 71, S_OVR, 12'd1); pin(t + 71, S_CNT, 12'd1); pin(t + 71, S_DATO, 12'h3C5);
      driveAt(t + 75);
      adcEn = 1'b0;
      cutAt(t + 76);
      pin(t + 77, S_OVR, 12'd0);

      // edge seen while disabled is lost
      driveAt(t + 78);
      trigger(1'b0, 12'd0, 12'h000, 1'b0, t2);
      driveAt(t + 83);
      adcEn = 1'b1;
      pin(t + 85, S_OVR, 12'd0); pin(t + 85, S_STATE, 12'(IDLE));

      // abort during third sample of a five-sample burst
      driveAt(t + 88);
      trigger(1'b1, 12'd5, 12'h200, 1'b1, t);
      a = t + 2*PER + 40;
      driveAt(a);
      adcEn = 1'b0;
      cutAt(a + 1);
      pin(a + 1, S_CS, 12'd1);
      pin(a + 3, S_CNT, 12'd2); pin(a + 3, S_BUSY, 12'd0);
      pin(a + 3, S_DATO, 12'h201); pin(a + 3, S_STATE, 12'(IDLE));
      driveAt(a + 5);
      adcEn = 1'b1;

      // zero-length burst
      driveAt(a + 8);
      trigger(1'b1, 12'd0, 12'h000, 1'b1, t);
      pin(t + 1, S_DONE, 12'd1); pin(t + 1, S_BUSY, 12'd0);
      pin(t + 1, S_CNT, 12'd0);  pin(t + 2, S_STATE, 12'(IDLE));

      // reset mid-frame, then a clean frame
      driveAt(t + 5);
      trigger(1'b0, 12'd0, 12'h5A5, 1'b1, t);
      driveAt(t + 20);
      rst = 1'b1;
      cutAt(t + 20);
      setCnt(t + 20, 12'd0);
      pin(t + 20, S_CS, 12'd1);  pin(t + 20, S_SCLK, 12'd1);
      pin(t + 20, S_DATO, 12'd0); pin(t + 20, S_CNT, 12'd0);
      driveAt(t + 22);
      rst = 1'b0;
      driveAt(t + 25);
      trigger(1'b0, 12'd0, 12'h7E1, 1'b1, t2);
      pin(t2 + 66, S_READY, 12'd1); pin(t2 + 66, S_DATO, 12'h7E1);
      pin(t2 + 70, S_DONE, 12'd1);
      driveAt(t2 + 75);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
